rf_port_sequencer: RTL and testbench
====================================

// Module: rf_port_sequencer
// PURPOSE
//  Feeds the single-port register file (one Addr, comb read, clocked write), directly upstream of it.
//  Buffers writeback results (addr,data) in a small FIFO and drains one per idle cycle into the RF.
//  Arbitrates the shared Addr port between decode reads (priority) and queued writes.
//  Keeps reads coherent with queued-but-unwritten results.
// PARAMETERS
//  W          8  data width
//  A          4  RF address width (2**A registers)
//  DEPTH      4  write FIFO entries (power of 2, >=2)
//  MAX_STARVE 3  max consecutive granted reads while FIFO non-empty before a forced drain
// PORTS
//  Clk        in   1  clock, all state on posedge
//  Reset_n    in   1  asynchronous, active-low reset
//  WrValid    in   1  writeback result offered
//  WrReady    out  1  FIFO can accept; push = WrValid & WrReady
//  WrAddr     in   A  destination register
//  WrData     in   W  result value
//  RdValid    in   1  decode read request
//  RdReady    out  1  read granted this cycle; RdData valid same cycle
//  RdAddr     in   A  source register
//  RdData     out  W  read result (comb)
//  RfWriteEn  out  1  to RF WriteEn
//  RfAddr     out  A  to RF Addr
//  RfDataIn   out  W  to RF DataIn
//  RfDataOut  in   W  from RF DataOut
// BEHAVIOUR
//  - Reset (Reset_n=0, async): wr/rd ptrs, count, starve counter -> 0; queued writes discarded.
//    While Reset_n=0: WrReady=0, RdReady=0, RfWriteEn=0, RfAddr=0, RfDataIn=0, RdData=0.
//  - WrReady = Reset_n & (count < DEPTH). Full FIFO never accepts, even if popping same cycle.
//  - hazard = some stored FIFO entry has addr == RdAddr (entry being pushed this cycle excluded).
//  - force = (count==DEPTH) | (starve==MAX_STARVE).
//  - RdReady = RdValid & ~force & (bypass-enabled | ~hazard).
//  - Port select, one per cycle: RdReady -> RfAddr=RdAddr, RfWriteEn=0.
//    Else count>0 -> RfAddr/RfDataIn = head entry, RfWriteEn=1, pop at posedge.
//    Else RfWriteEn=0, RfAddr=0.
//  - Push/pop same cycle: count unchanged, both ptrs advance (wrap mod DEPTH).
//  - Write latency: pushed entry reaches RF no earlier than next cycle; FIFO order preserved.
//  - starve: +1 on cycle with RdReady & count>0; cleared on any pop or when count==0; saturates.
//  - Read of register with no queued entry: RdData = RfDataOut.
//  - Multiple same-addr queued entries are all written in order (no merging).
// CONFIGURATION
//  RF_BYPASS_EN defined: on hazard, read is granted; RdData = data of NEWEST matching stored
//    entry (youngest by FIFO order), else RfDataOut.
//  RF_BYPASS_EN undefined: on hazard, RdReady=0 and port drains FIFO until no match;
//    RdData = RfDataOut always.
// TESTING
//  1. Reset, WrValid one cycle (r3,8'hA5), RdValid=0 -> next cycle RfWriteEn=1,RfAddr=3,RfDataIn=A5; read r3 after -> A5.
//  2. Push 4 writes back-to-back, RdValid held on r9 -> WrReady=0 at count 4; RdReady=0 while full; drains resume.
//  3. RdValid held on r1, queue (r2,11) -> 3 reads granted, cycle 4 RdReady=0, RfWriteEn=1 (forced drain), starve->0.
//  4. Queue (r5,01),(r5,02), read r5: BYPASS_EN -> RdReady=1, RdData=02; else RdReady=0 two drain cycles then RdData=02.
//  5. Queue 3 writes, assert Reset_n=0 mid-drain -> RfWriteEn drops immediately; after release count=0, RF regs unchanged.
//  6. Simultaneous push and pop at count=2 for 8 cycles -> count stays 2, ptrs wrap, RF sees writes in push order.

Source files
------------

// File: rtl/rf_port_sequencer_if.sv
// Bundle of the write-back, decode-read and register-file port signals
// around rf_port_sequencer. The master side is the surrounding pipeline plus
// the register file; the slave side is the sequencer.
interface rf_port_sequencer_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic         WrValid;
  logic         WrReady;
  logic [A-1:0] WrAddr;
  logic [W-1:0] WrData;
  logic         RdValid;
  logic         RdReady;
  logic [A-1:0] RdAddr;
  logic [W-1:0] RdData;
  logic         RfWriteEn;
  logic [A-1:0] RfAddr;
  logic [W-1:0] RfDataIn;
  logic [W-1:0] RfDataOut;

  modport master (
    output WrValid, WrAddr, WrData, RdValid, RdAddr, RfDataOut,
    input  WrReady, RdReady, RdData, RfWriteEn, RfAddr, RfDataIn
  );

  modport slave (
    input  WrValid, WrAddr, WrData, RdValid, RdAddr, RfDataOut,
    output WrReady, RdReady, RdData, RfWriteEn, RfAddr, RfDataIn
  );
endinterface

// File: rtl/rf_port_sequencer.sv
// rf_port_sequencer: sits in front of a single-port register file (one
// address, combinational read, clocked write). Write-back results are queued
// in a small FIFO and drained into the RF on cycles the decode stage does not
// need the port. Decode reads have priority, bounded by a starvation limit and
// by a full queue, both of which force a drain cycle.
//
// Build option: define RF_BYPASS_EN to let reads that hit a queued write be
// granted immediately with the youngest matching queued value. Without it,
// such reads are held off while the port drains the queue past the match.
module rf_port_sequencer #(
  parameter int W          = 8,
  parameter int A          = 4,
  parameter int DEPTH      = 4,
  parameter int MAX_STARVE = 3
) (
  input logic                Clk,
  input logic                Reset_n,
  rf_port_sequencer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);

  logic [A-1:0]  addr_q [DEPTH];
  logic [W-1:0]  data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          not_empty;
  logic          hazard;
  logic          force_drain;
  logic          rd_grant;
  logic          push;
  logic          pop;
  logic [PW-1:0] slot;
`ifdef RF_BYPASS_EN
  logic [W-1:0]  match_data;
`endif

  assign not_empty   = (count != '0);
  assign force_drain = (count == FULL) || (starve == STARVE_LIM);

  // Scan occupied entries oldest to youngest for the read address; the last
  // hit wins, so the captured data is from the newest matching write.
  always_comb begin
    hazard = 1'b0;
    slot   = rd_ptr;
`ifdef RF_BYPASS_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (addr_q[slot] == bus.RdAddr)) begin
        hazard = 1'b1;
`ifdef RF_BYPASS_EN
        match_data = data_q[slot];
`endif
      end
    end
  end

`ifdef RF_BYPASS_EN
  assign rd_grant = Reset_n & bus.RdValid & ~force_drain;
`else
  assign rd_grant = Reset_n & bus.RdValid & ~force_drain & ~hazard;
`endif

  // A full queue refuses pushes even when it is popping in the same cycle.
  assign bus.WrReady = Reset_n & (count < FULL);
  assign push        = bus.WrValid & bus.WrReady;
  assign pop         = Reset_n & ~rd_grant & not_empty;

  assign bus.RdReady   = rd_grant;
  assign bus.RfWriteEn = pop;
  assign bus.RfAddr    = rd_grant ? bus.RdAddr :
                         pop      ? addr_q[rd_ptr] : '0;
  assign bus.RfDataIn  = pop ? data_q[rd_ptr] : '0;

`ifdef RF_BYPASS_EN
  assign bus.RdData = !Reset_n ? '0 :
                      hazard   ? match_data : bus.RfDataOut;
`else
  assign bus.RdData = Reset_n ? bus.RfDataOut : '0;
`endif

  // Pointers, occupancy and the count of reads granted since the last drain.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || !not_empty)
        starve <= '0;
      else if (rd_grant && (starve != STARVE_LIM))
        starve <= starve + SW'(1);
    end
  end

  // Entry storage; a slot's contents only matter while it is counted as occupied.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.WrAddr;
      data_q[wr_ptr] <= bus.WrData;
    end
  end

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Bench for rf_port_sequencer: a register-file model on the RF side, directed
// stimulus with literal expectations at key cycles, and a queue-based model
// of the sequencer checked against the DUT at every negedge.
`timescale 1ns/1ps
module tb_rf_port_sequencer;
  localparam int W = 8;
  localparam int A = 4;
  localparam int DEPTH = 4;
  localparam int MAX_STARVE = 3;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } ent_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rf_port_sequencer_if #(.W(W), .A(A)) bus ();

  rf_port_sequencer #(.W(W), .A(A), .DEPTH(DEPTH), .MAX_STARVE(MAX_STARVE)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] init_val(input int i);
    return W'(8'h30 + i);
  endfunction

  // Register file: combinational read, clocked write, preset on first edge.
  logic [W-1:0] rf [16];
  logic         rf_loaded = 1'b0;
  assign bus.RfDataOut = rf[bus.RfAddr];
  always @(posedge Clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
      rf_loaded <= 1'b1;
    end else if (bus.RfWriteEn) begin
      rf[bus.RfAddr] <= bus.RfDataIn;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  ent_t         q[$];
  logic [W-1:0] mrf [16];
  int           m_starve;
  int           m_cnt;
  bit           m_hz, m_frc, m_erd, m_ewr, m_ewe;
  logic [W-1:0] m_bd;
  logic [A-1:0] m_ea;

  // Compare DUT against the model mid-cycle, then advance the model across the coming edge.
  initial begin
    for (int i = 0; i < 16; i++) mrf[i] = init_val(i);
    m_starve = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        chk("rst_wrready", bus.WrReady, 0);
        chk("rst_rdready", bus.RdReady, 0);
        chk("rst_rfwe", bus.RfWriteEn, 0);
        chk("rst_rfaddr", bus.RfAddr, 0);
        chk("rst_rfdin", bus.RfDataIn, 0);
        chk("rst_rddata", bus.RdData, 0);
        q.delete();
        m_starve = 0;
      end else begin
        m_cnt = q.size();
        m_hz = 1'b0;
        m_bd = '0;
        foreach (q[k]) if (q[k].a == bus.RdAddr) begin m_hz = 1'b1; m_bd = q[k].d; end
        m_frc = (m_cnt == DEPTH) || (m_starve == MAX_STARVE);
        m_ewr = (m_cnt < DEPTH);
        m_erd = bus.RdValid && !m_frc && (BYP || !m_hz);
        m_ewe = !m_erd && (m_cnt > 0);
        m_ea  = m_erd ? bus.RdAddr : (m_ewe ? q[0].a : '0);
        chk("m_wrready", bus.WrReady, m_ewr);
        chk("m_rdready", bus.RdReady, m_erd);
        chk("m_rfwe", bus.RfWriteEn, m_ewe);
        chk("m_rfaddr", bus.RfAddr, m_ea);
        if (m_ewe) chk("m_rfdin", bus.RfDataIn, q[0].d);
        if (m_erd) chk("m_rddata", bus.RdData, (m_hz && BYP) ? m_bd : mrf[bus.RdAddr]);
        if (m_ewe) begin
          mrf[q[0].a] = q[0].d;
          void'(q.pop_front());
          m_starve = 0;
        end else if (m_cnt == 0) begin
          m_starve = 0;
        end else if (m_erd && m_starve < MAX_STARVE) begin
          m_starve++;
        end
        if (bus.WrValid && m_ewr) q.push_back('{a: bus.WrAddr, d: bus.WrData});
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                       input logic rv, input logic [A-1:0] ra);
    bus.WrValid = wv;
    bus.WrAddr  = wa;
    bus.WrData  = wd;
    bus.RdValid = rv;
    bus.RdAddr  = ra;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive(1'b0, '0, '0, 1'b0, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Requests held high during reset must be refused.
    drive(1'b1, 4'd3, 8'h77, 1'b1, 4'd3);
    step();
    chk("rst_lit_we", bus.RfWriteEn, 0);
    chk("rst_lit_wr", bus.WrReady, 0);
    chk("rst_lit_rd", bus.RdReady, 0);
    step();
    Reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);

    // Single write reaches the RF one cycle later, then reads back.
    step();
    drive(1'b1, 4'd3, 8'hA5, 1'b0, '0);
    #1 chk("t1_wrready", bus.WrReady, 1);
    chk("t1_no_same_cycle_we", bus.RfWriteEn, 0);
    step();
    drive(1'b0, '0, '0, 1'b0, '0);
    #1 chk("t1_we", bus.RfWriteEn, 1);
    chk("t1_addr", bus.RfAddr, 3);
    chk("t1_din", bus.RfDataIn, 8'hA5);
    step();
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    #1 chk("t1_rdready", bus.RdReady, 1);
    chk("t1_rddata", bus.RdData, 8'hA5);

    // Fill the queue with reads held on r9.
    step(); drive(1'b1, 4'd4, 8'h11, 1'b1, 4'd9);
    step(); drive(1'b1, 4'd6, 8'h22, 1'b1, 4'd9);
    step(); drive(1'b1, 4'd7, 8'h33, 1'b1, 4'd9);
    step(); drive(1'b1, 4'd8, 8'h44, 1'b1, 4'd9);
    step(); drive(1'b1, 4'd10, 8'h55, 1'b1, 4'd9);
    #1 chk("t2_full_wrready", bus.WrReady, 0);
    chk("t2_full_rdready", bus.RdReady, 0);
    chk("t2_full_we", bus.RfWriteEn, 1);
    chk("t2_full_addr", bus.RfAddr, 4);
    step(); drive(1'b1, 4'd10, 8'h55, 1'b1, 4'd9);
    #1 chk("t2_after_wrready", bus.WrReady, 1);
    chk("t2_after_rdready", bus.RdReady, 1);
    idle(6);

    // Starvation limit forces a drain after three granted reads.
    step(); drive(1'b1, 4'd2, 8'h11, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      step(); drive(1'b0, '0, '0, 1'b1, 4'd1);
      #1 chk("t3_read_granted", bus.RdReady, 1);
    end
    step(); drive(1'b0, '0, '0, 1'b1, 4'd1);
    #1 chk("t3_forced_rdready", bus.RdReady, 0);
    chk("t3_forced_we", bus.RfWriteEn, 1);
    chk("t3_forced_addr", bus.RfAddr, 2);
    chk("t3_forced_din", bus.RfDataIn, 8'h11);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd1);
    #1 chk("t3_resume", bus.RdReady, 1);
    idle(2);

    // Two queued writes to r5, then a read of r5.
    step(); drive(1'b1, 4'd5, 8'h01, 1'b1, 4'd0);
    step(); drive(1'b1, 4'd5, 8'h02, 1'b1, 4'd0);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd5);
`ifdef RF_BYPASS_EN
    #1 chk("t4_byp_rdready", bus.RdReady, 1);
    chk("t4_byp_rddata", bus.RdData, 8'h02);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd5);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd5);
    #1 chk("t4_byp_forced", bus.RfWriteEn, 1);
`else
    #1 chk("t4_hold1", bus.RdReady, 0);
    chk("t4_drain1", bus.RfDataIn, 8'h01);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd5);
    #1 chk("t4_hold2", bus.RdReady, 0);
    chk("t4_drain2", bus.RfDataIn, 8'h02);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd5);
    #1 chk("t4_rdready", bus.RdReady, 1);
    chk("t4_rddata", bus.RdData, 8'h02);
`endif
    idle(5);

    // Reset in the middle of a drain discards what is still queued.
    step(); drive(1'b1, 4'd10, 8'hAA, 1'b1, 4'd0);
    step(); drive(1'b1, 4'd11, 8'hBB, 1'b1, 4'd0);
    step(); drive(1'b1, 4'd12, 8'hCC, 1'b1, 4'd0);
    step(); drive(1'b0, '0, '0, 1'b1, 4'd0);
    step(); drive(1'b0, '0, '0, 1'b0, '0);
    #1 chk("t5_drain_addr", bus.RfAddr, 10);
    step(); drive(1'b0, '0, '0, 1'b0, '0);
    #1 chk("t5_pre_rst_we", bus.RfWriteEn, 1);
    Reset_n = 1'b0;
    #1 chk("t5_rst_we", bus.RfWriteEn, 0);
    step();
    Reset_n = 1'b1;
    idle(3);
    chk("t5_after_we", bus.RfWriteEn, 0);
    chk("t5_r10", rf[10], 8'hAA);
    chk("t5_r11", rf[11], init_val(11));
    chk("t5_r12", rf[12], init_val(12));

    // Steady push and pop at two entries deep, wrapping the pointers.
    step(); drive(1'b1, 4'd1, 8'h61, 1'b1, 4'd0);
    step(); drive(1'b1, 4'd2, 8'h62, 1'b1, 4'd0);
    for (int k = 0; k < 8; k++) begin
      step(); drive(1'b1, A'(3 + k), W'(8'h63 + k), 1'b0, '0);
      #1 chk("t6_wrready", bus.WrReady, 1);
      chk("t6_we", bus.RfWriteEn, 1);
      chk("t6_addr", bus.RfAddr, (k < 2) ? 1 + k : 3 + k - 2);
    end
    idle(5);

    for (int i = 0; i < 16; i++) chk("final_rf", rf[i], mrf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
